out_path_sequencer: RTL
=======================

Name: out_path_sequencer

Overview:
Sequences every output-path change ahead of the HDMI transmitter. Covered changes are a test-pattern/scanconverter source switch, a CPU mode reprogram, and scanconverter PLL lock loss. Each change runs blank → TX reset → PLL lock qualification → unblank. The block sits in the clk27 domain between the system CPU controls and the top-level output mux, and replaces the direct sys_ctrl-driven mux select and TX reset.

Parameters:
BLANK_CYCLES, 64, cycles blank_out is held before the TX reset/source switch (≥1)
RST_CYCLES, 32, cycles tx_reset_n is held low (≥1)
LOCK_STABLE_CYCLES, 1024, consecutive pll_locked=1 cycles required to qualify lock (≥1)
LOCK_TIMEOUT_CYCLES, 1048576, maximum WAIT_LOCK duration before timeout (> LOCK_STABLE_CYCLES)
CNT_W, 21, shared counter width; must hold LOCK_TIMEOUT_CYCLES

Ports:
clk27  in  1  system clock, 27 MHz
reset  in  1  synchronous, active-high reset
src_sel_req  in  1  requested source: 1 = scanconverter, 0 = videogen
mode_change  in  1  single-cycle pulse; CPU rewrote h_info/v_info
pll_locked  in  1  scanconverter PLL lock, already synchronized to clk27
resync_on_unlock  in  1  1 = lock loss while in RUN triggers a resequence
err_clr  in  1  single-cycle pulse; clears timeout_err
src_sel_out  out  1  registered select to the output mux
blank_out  out  1  1 = force DE low and RGB to 0 at the output mux
tx_reset_n  out  1  HDMI TX reset, active-low
busy  out  1  1 whenever state != RUN
timeout_err  out  1  sticky lock-timeout flag

Behaviour:
- All outputs are registered. Single shared counter cnt[CNT_W-1:0].
- Reset values:
  - state=TX_RST, cnt=0
  - src_sel_out=0, blank_out=1, tx_reset_n=0, busy=1, timeout_err=0, pending=0
- States: RUN, BLANK, TX_RST, WAIT_LOCK.
- trigger = (src_sel_req != src_sel_out) | mode_change | (resync_on_unlock & src_sel_out & ~pll_locked).
- RUN:
  - blank_out=0, tx_reset_n=1, busy=0.
  - On trigger: next cycle state=BLANK, cnt=0, blank_out=1, busy=1. Latency from trigger to blank_out=1 is 1 cycle.
- BLANK:
  - cnt increments each cycle.
  - When cnt==BLANK_CYCLES-1: state=TX_RST, cnt=0, tx_reset_n=0, src_sel_out<=src_sel_req (the source is sampled only here).
- TX_RST:
  - tx_reset_n low for exactly RST_CYCLES cycles.
  - At the end: tx_reset_n=1, cnt=0. Next state is WAIT_LOCK if src_sel_out=1, else RUN (videogen runs on clk27 and needs no lock).
  - Exit from reset: TX_RST runs with src_sel_out=0, so the first RUN always uses videogen.
- WAIT_LOCK:
  - stable counter: increments while pll_locked=1, returns to 0 on any pll_locked=0 cycle.
  - Timeout counter cnt increments every cycle.
  - Exit to RUN when the stable count reaches LOCK_STABLE_CYCLES.
  - Otherwise, when cnt==LOCK_TIMEOUT_CYCLES-1: set timeout_err=1 and go to RUN (blank_out=0, best effort).
  - Stable qualification takes priority on the same cycle as timeout.
- Requests while busy:
  - A mode_change pulse or a src_sel_req edge in BLANK/TX_RST/WAIT_LOCK sets pending=1.
  - A src_sel_req edge during BLANK is absorbed by the sampling in TX_RST and does not set pending.
  - Entry into RUN with pending=1 goes directly to BLANK in the same transition; pending clears and blank_out never deasserts.
- timeout_err: set by a timeout, cleared by err_clr. If both occur in the same cycle, set wins.
- reset asserted mid-sequence restores the reset values on the next edge; pending and counters are discarded.
- Outputs change in no state other than as stated; there are no glitches on src_sel_out.

Decomposition:
- Package out_seq_pkg holds:
  - state enum: RUN=2'd0, BLANK=2'd1, TX_RST=2'd2, WAIT_LOCK=2'd3
  - CNT_W default
- One sub-module, lock_qualifier, contains the stable counter. Its ports are clk27, reset, clr, locked_in, and qualified_out, where qualified_out is high when count ≥ LOCK_STABLE_CYCLES.

Test Plan:
All scenarios use BLANK_CYCLES=4, RST_CYCLES=8, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=100.
1. Release reset with src_sel_req=0 → tx_reset_n low 8 cycles, then RUN. blank_out=0, busy=0, src_sel_out=0 at cycle 9.
2. In RUN, src_sel_req 0→1 with pll_locked=1 → blank_out=1 after 1 cycle; src_sel_out=1 at blank+4; tx_reset_n low 8 cycles; unblank 16 cycles later; total 29 cycles busy.
3. Same as 2, but pll_locked toggles 0 at cycle 10 of WAIT_LOCK → the stable count restarts and exit is delayed by 11 cycles.
4. Switch to 1 with pll_locked=0 throughout → timeout_err=1 and RUN after 100 WAIT_LOCK cycles. err_clr clears it. err_clr coincident with a timeout → timeout_err stays 1.
5. mode_change pulse during TX_RST → after the sequence completes, BLANK re-enters with no blank_out=0 cycle; a second full sequence runs.
6. Assert reset in WAIT_LOCK → the next cycle shows src_sel_out=0, blank_out=1, tx_reset_n=0, timeout_err=0.

Source files
------------

// File: rtl/out_seq_pkg.sv
// Output-path sequencer package: shared state encoding and the default
// width of the shared sequencing counter.
package out_seq_pkg;

  // Wide enough for the default lock timeout of 2^20 cycles.
  localparam int CNT_W_DEF = 21;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    BLANK     = 2'd1,
    TX_RST    = 2'd2,
    WAIT_LOCK = 2'd3
  } seq_state_t;

endpackage

// File: rtl/lock_qualifier.sv
// Lock qualifier: counts consecutive cycles of locked_in=1 and reports when
// that run reaches LOCK_STABLE_CYCLES.
//   clk27         in   system clock
//   reset         in   synchronous active-high reset
//   clr           in   holds the stable count at zero
//   locked_in     in   PLL lock, already synchronized to clk27
//   qualified_out out  high while the stable count >= LOCK_STABLE_CYCLES
module lock_qualifier #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CNT_W              = 21
) (
  input  logic clk27,
  input  logic reset,
  input  logic clr,
  input  logic locked_in,
  output logic qualified_out
);

  localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(LOCK_STABLE_CYCLES);

  logic [CNT_W-1:0] stable_cnt;

  // Saturates at the threshold so a long lock never wraps back below it.
  always_ff @(posedge clk27) begin
    if (reset || clr || !locked_in) begin
      stable_cnt <= '0;
    end else if (stable_cnt < STABLE_TC) begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  assign qualified_out = (stable_cnt >= STABLE_TC);

endmodule

// File: rtl/out_path_sequencer.sv
// Output-path sequencer: every source switch, mode reprogram or (optionally)
// scanconverter lock loss runs blank -> TX reset -> lock qualification ->
// unblank ahead of the HDMI transmitter.
//   clk27            in   system clock, 27 MHz
//   reset            in   synchronous active-high reset
//   src_sel_req      in   requested source: 1 = scanconverter, 0 = videogen
//   mode_change      in   single-cycle pulse, timing registers rewritten
//   pll_locked       in   scanconverter PLL lock (clk27 domain)
//   resync_on_unlock in   lock loss in RUN triggers a resequence
//   err_clr          in   single-cycle pulse, clears timeout_err
//   src_sel_out      out  registered output mux select
//   blank_out        out  force DE low / RGB to 0
//   tx_reset_n       out  HDMI TX reset, active-low
//   busy             out  high whenever not in RUN
//   timeout_err      out  sticky lock-timeout flag
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | output live, watching for triggers
// BLANK     | output blanked, waiting BLANK_CYCLES before the switch
// TX_RST    | TX held in reset for RST_CYCLES, new source already selected
// WAIT_LOCK | scanconverter source, waiting for a stable PLL lock or timeout
module out_path_sequencer
  import out_seq_pkg::*;
#(
  parameter int BLANK_CYCLES        = 64,
  parameter int RST_CYCLES          = 32,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int CNT_W               = CNT_W_DEF
) (
  input  logic clk27,
  input  logic reset,
  input  logic src_sel_req,
  input  logic mode_change,
  input  logic pll_locked,
  input  logic resync_on_unlock,
  input  logic err_clr,
  output logic src_sel_out,
  output logic blank_out,
  output logic tx_reset_n,
  output logic busy,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] BLANK_TC   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_TC     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic             src_req_q;
  logic             lock_qualified;

  logic trigger;
  logic src_edge;
  logic pending_set;
  logic timeout_hit;
  logic seq_exit;

  lock_qualifier #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .CNT_W             (CNT_W)
  ) u_lock_qualifier (
    .clk27        (clk27),
    .reset        (reset),
    .clr          (state != WAIT_LOCK),
    .locked_in    (pll_locked),
    .qualified_out(lock_qualified)
  );

  always_comb begin
    trigger     = (src_sel_req != src_sel_out) | mode_change |
                  (resync_on_unlock & src_sel_out & ~pll_locked);
    src_edge    = src_sel_req ^ src_req_q;
    pending_set = 1'b0;
    timeout_hit = 1'b0;
    seq_exit    = 1'b0;
    case (state)
      // A source edge while blanking is picked up by the TX_RST sample.
      BLANK:     pending_set = mode_change;
      TX_RST: begin
        pending_set = mode_change | src_edge;
        seq_exit    = (cnt == RST_TC) & ~src_sel_out;
      end
      WAIT_LOCK: begin
        pending_set = mode_change | src_edge;
        timeout_hit = ~lock_qualified & (cnt == TIMEOUT_TC);
        seq_exit    = lock_qualified | timeout_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk27) begin
    if (reset) begin
      state       <= TX_RST;
      cnt         <= '0;
      src_sel_out <= 1'b0;
      blank_out   <= 1'b1;
      tx_reset_n  <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
      pending     <= 1'b0;
      src_req_q   <= src_sel_req;
    end else begin
      src_req_q <= src_sel_req;

      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end

      case (state)
        RUN: begin
          if (trigger) begin
            state     <= BLANK;
            cnt       <= '0;
            blank_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        BLANK: begin
          if (cnt == BLANK_TC) begin
            state       <= TX_RST;
            cnt         <= '0;
            tx_reset_n  <= 1'b0;
            src_sel_out <= src_sel_req;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX_RST: begin
          if (cnt == RST_TC) begin
            tx_reset_n <= 1'b1;
            cnt        <= '0;
            if (src_sel_out) begin
              state <= WAIT_LOCK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: cnt <= cnt + 1'b1;
      endcase

      // Leaving the sequence: a request that arrived while busy (including
      // one arriving right now) restarts blanking without ever unblanking.
      if (seq_exit) begin
        cnt     <= '0;
        pending <= 1'b0;
        if (pending || pending_set) begin
          state <= BLANK;
        end else begin
          state     <= RUN;
          blank_out <= 1'b0;
          busy      <= 1'b0;
        end
      end else if (pending_set) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
